// File: rtl/serial_adder_if.sv
// Handshake/operand/result bundle for serial_adder.
// ovf and its modport entries exist only when SERIAL_ADD_OVF_EN is defined.

interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;

   modport master (output start, a, b, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, input busy, done, sum, cout);
   modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two half_add cells + OR),
// operands shifted LSB-first. Signed overflow output enabled by SERIAL_ADD_OVF_EN.

module half_add (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);
   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_sum_sr;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
   logic             r_ovf;
`endif

   logic             w_s0;
   logic             w_c0;
   logic             w_s;
   logic             w_c1;
   logic             w_c;
   logic             w_last;
   logic             w_load;
   logic             w_step;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [WIDTH-1:0] w_sum_sr_nxt;

   // Full-adder slice on the current LSBs and the held carry.
   half_add u_ha0 (.a(r_a_sr[0]), .b(r_b_sr[0]), .s(w_s0), .c(w_c0));
   half_add u_ha1 (.a(w_s0),      .b(r_carry),   .s(w_s),  .c(w_c1));
   assign w_c          = w_c0 | w_c1;
   assign w_last       = (r_cnt == CNT_LAST);
   assign w_sum_sr_nxt = {w_s, r_sum_sr[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/control decode; busy and done are registered from the next state.
   always_comb begin
      w_load     = 1'b0;
      w_step     = 1'b0;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      case (r_state)
         S_IDLE:  w_load = bus.start;
         S_RUN:   w_step = 1'b1;
         S_DONE:  w_load = 1'b0;
         default: w_load = 1'b0;
      endcase
      case (w_state_nxt)
         S_RUN:   w_busy_nxt = 1'b1;
         S_DONE: begin
            w_busy_nxt = 1'b1;
            w_done_nxt = 1'b1;
         end
         S_IDLE:  w_busy_nxt = 1'b0;
         default: w_busy_nxt = 1'b0;
      endcase
   end

   // Status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   // Operand shifters, carry, counter and the captured result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_sr   <= {WIDTH{1'b0}};
         r_b_sr   <= {WIDTH{1'b0}};
         r_sum_sr <= {WIDTH{1'b0}};
         r_carry  <= 1'b0;
         r_cnt    <= {CNT_W{1'b0}};
         r_sum    <= {WIDTH{1'b0}};
         r_cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else if (w_load) begin
         r_a_sr  <= bus.a;
         r_b_sr  <= bus.b;
         r_carry <= 1'b0;
         r_cnt   <= {CNT_W{1'b0}};
      end else if (w_step) begin
         r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
         r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
         r_sum_sr <= w_sum_sr_nxt;
         r_carry  <= w_c;
         if (w_last) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_sum  <= w_sum_sr_nxt;
            r_cout <= w_c;
`ifdef SERIAL_ADD_OVF_EN
            // On the last slice r_carry is the carry into the MSB.
            r_ovf  <= r_carry ^ w_c;
`endif
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=4 instances on one clock.

module tb_serial_adder;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   lat;
   int   pulses;

   serial_adder_if #(.WIDTH(8)) if8 ();
   serial_adder_if #(.WIDTH(4)) if4 ();

   serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
   serial_adder #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start accepted on the first edge; returns 1 ns after that edge.
   task automatic start8(input logic [7:0] a, input logic [7:0] b);
      if8.a = a;
      if8.b = b;
      if8.start = 1'b1;
      tick();
      if8.start = 1'b0;
   endtask

   task automatic start4(input logic [3:0] a, input logic [3:0] b);
      if4.a = a;
      if4.b = b;
      if4.start = 1'b1;
      tick();
      if4.start = 1'b0;
   endtask

   // lat counts edges from the accepting edge (=1) to the edge that raises done.
   task automatic wait_done8(output int n);
      n = 1;
      while (if8.done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_done4(output int n);
      n = 1;
      while (if4.done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      if8.start = 1'b0;
      if8.a     = 8'h00;
      if8.b     = 8'h00;
      if4.start = 1'b0;
      if4.a     = 4'h0;
      if4.b     = 4'h0;
      tick();
      tick();
      chk("rst_busy", 32'(if8.busy), 32'd0);
      chk("rst_done", 32'(if8.done), 32'd0);
      chk("rst_sum",  32'(if8.sum),  32'd0);
      chk("rst_cout", 32'(if8.cout), 32'd0);
      rst = 1'b0;
      tick();

      // 1: 00+00, latency and single-cycle done
      start8(8'h00, 8'h00);
      chk("t1_busy_run", 32'(if8.busy), 32'd1);
      wait_done8(lat);
      chk("t1_latency", 32'(lat), 32'd9);
      chk("t1_sum",  32'(if8.sum),  32'h00);
      chk("t1_cout", 32'(if8.cout), 32'd0);
      tick();
      chk("t1_done_low", 32'(if8.done), 32'd0);
      tick();
      chk("t1_idle_busy", 32'(if8.busy), 32'd0);

      // 2: FF+01
      start8(8'hFF, 8'h01);
      wait_done8(lat);
      chk("t2_sum",  32'(if8.sum),  32'h00);
      chk("t2_cout", 32'(if8.cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
      chk("t2_ovf",  32'(if8.ovf),  32'd0);
`endif
      tick();
      tick();

      // 3: 7F+01 then 80+80
      start8(8'h7F, 8'h01);
      wait_done8(lat);
      chk("t3a_sum",  32'(if8.sum),  32'h80);
      chk("t3a_cout", 32'(if8.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("t3a_ovf",  32'(if8.ovf),  32'd1);
`endif
      for (int i = 0; i < 5; i++) tick();
      chk("t3a_hold_sum", 32'(if8.sum), 32'h80);
      start8(8'h80, 8'h80);
      chk("t3b_sum_stable_run", 32'(if8.sum), 32'h80);
      wait_done8(lat);
      chk("t3b_sum",  32'(if8.sum),  32'h00);
      chk("t3b_cout", 32'(if8.cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
      chk("t3b_ovf",  32'(if8.ovf),  32'd1);
`endif
      tick();
      tick();

      // 4: 0F+01 with a second start mid-run
      start8(8'h0F, 8'h01);
      tick();
      if8.a = 8'hAA;
      if8.start = 1'b1;
      tick();
      if8.start = 1'b0;
      if8.a = 8'h00;
      lat = 3;
      while (if8.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      chk("t4_latency", 32'(lat), 32'd9);
      chk("t4_sum",  32'(if8.sum),  32'h10);
      chk("t4_cout", 32'(if8.cout), 32'd0);
      pulses = 1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (if8.done === 1'b1) pulses++;
      end
      chk("t4_done_pulses", 32'(pulses), 32'd1);

      // 5: reset in the middle of an add
      start8(8'hFF, 8'hFF);
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("t5_busy_async", 32'(if8.busy), 32'd0);
      chk("t5_sum_async",  32'(if8.sum),  32'h00);
      tick();
      rst = 1'b0;
      tick();
      start8(8'h12, 8'h34);
      wait_done8(lat);
      chk("t5_latency", 32'(lat), 32'd9);
      chk("t5_sum",  32'(if8.sum),  32'h46);
      chk("t5_cout", 32'(if8.cout), 32'd0);
      tick();

      // 6: WIDTH=4, then back-to-back start that would expose a leaked carry
      start4(4'hF, 4'hF);
      wait_done4(lat);
      chk("t6_latency", 32'(lat), 32'd5);
      chk("t6_sum",  32'(if4.sum),  32'hE);
      chk("t6_cout", 32'(if4.cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
      chk("t6_ovf",  32'(if4.ovf),  32'd0);
`endif
      if4.a = 4'h1;
      if4.b = 4'h2;
      if4.start = 1'b1;
      tick();
      tick();
      if4.start = 1'b0;
      wait_done4(lat);
      chk("t6b_latency", 32'(lat), 32'd5);
      chk("t6b_sum",  32'(if4.sum),  32'h3);
      chk("t6b_cout", 32'(if4.cout), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
